// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit for the exp5 accumulator CPU: PC, IR, JMP/BAN redirection, STP halt.
// Optional retired-instruction counter enabled by defining FETCH_RETCNT_EN.
module ins_fetch_unit #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned OP_W     = 7,
  parameter int unsigned INS_W    = OP_W + ADDR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_rdata,
  output logic [OP_W-1:0]   ins,
  output logic [ADDR_W-1:0] ins_addr,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic              acc_neg,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef FETCH_RETCNT_EN
  ,
  output logic [31:0]       ret_cnt
`endif
);

  localparam logic [OP_W-1:0] OP_STP = OP_W'(7'b0000100);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(7'b0001000);
  localparam logic [OP_W-1:0] OP_BAN = OP_W'(7'b0001001);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            state;
  logic [INS_W-1:0]  ir;
  logic              handshake;

  assign ins       = ir[INS_W-1:ADDR_W];
  assign ins_addr  = ir[ADDR_W-1:0];
  assign imem_addr = pc;
  assign ins_valid = (state == S_ISSUE);
  assign halted    = (state == S_HALT);
  assign handshake = ins_valid && ins_ready;
  // Reset parks the FSM in S_FETCH; masking with rst keeps the read idle while reset is held.
  assign imem_en   = (state == S_FETCH) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= ADDR_W'(RESET_PC);
      ir    <= '0;
    end else begin
      unique case (state)
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          ir    <= imem_rdata;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (handshake) begin
            state <= S_FETCH;
            if (ins == OP_JMP) begin
              pc <= ins_addr;
            end else if (ins == OP_BAN) begin
              pc <= acc_neg ? ins_addr : pc + 1'b1;
            end else if (ins == OP_STP) begin
              state <= S_HALT;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_RETCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_cnt <= '0;
    end else if (handshake) begin
      ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Self-checking bench for ins_fetch_unit: directed program plus randomized program
// checked against a per-instruction architectural model of the PC.
module tb_ins_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [6:0]  ins;
  logic [8:0]  ins_addr;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic        acc_neg = 1'b0;
  logic [8:0]  pc;
  logic        halted;
`ifdef FETCH_RETCNT_EN
  logic [31:0] ret_cnt;
`endif

  logic [15:0] mem [512];
  logic [8:0]  mpc;
  logic [31:0] mret;
  int          checks = 0;
  int          errors = 0;

  ins_fetch_unit #(.ADDR_W(9), .OP_W(7), .INS_W(16), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .ins_addr   (ins_addr),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .acc_neg    (acc_neg),
    .pc         (pc),
    .halted     (halted)
`ifdef FETCH_RETCNT_EN
    ,
    .ret_cnt    (ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_retcnt();
`ifdef FETCH_RETCNT_EN
    chk("ret_cnt", ret_cnt, mret);
`endif
  endtask

  // Leaves the bench at the negedge of the first fetch cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ins_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ins", 32'(ins), 32'd0);
    chk("rst_ins_addr", 32'(ins_addr), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    mpc  = '0;
    mret = '0;
    chk_retcnt();
    rst = 1'b0;
    #1;
    chk("start_imem_en", 32'(imem_en), 32'd1);
    chk("start_imem_addr", 32'(imem_addr), 32'd0);
  endtask

  // Called at the negedge of a fetch cycle; issues one instruction and checks the redirect.
  task automatic issue(input int delay, input logic neg);
    int          waited = 0;
    logic [15:0] w;
    logic [6:0]  op;
    logic [8:0]  a;
    do begin
      @(negedge clk);
      waited++;
    end while (!ins_valid && waited < 8);
    chk("valid_arrive", 32'(ins_valid), 32'd1);
    chk("valid_latency", 32'(waited), 32'd2);
    w  = mem[mpc];
    op = w[15:9];
    a  = w[8:0];
    chk("ins", 32'(ins), 32'(op));
    chk("ins_addr", 32'(ins_addr), 32'(a));
    chk("issue_pc", 32'(pc), 32'(mpc));
    chk("issue_imem_en", 32'(imem_en), 32'd0);
    for (int i = 0; i < delay; i++) begin
      acc_neg = 1'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(ins_valid), 32'd1);
      chk("bp_ins", 32'(ins), 32'(op));
      chk("bp_ins_addr", 32'(ins_addr), 32'(a));
      chk("bp_imem_en", 32'(imem_en), 32'd0);
    end
    ins_ready = 1'b1;
    acc_neg   = neg;
    @(negedge clk);
    ins_ready = 1'b0;
    acc_neg   = 1'($urandom);
    mret = mret + 32'd1;
    case (op)
      7'b0001000: mpc = a;
      7'b0001001: mpc = neg ? a : mpc + 9'd1;
      7'b0000100: ;
      default:    mpc = mpc + 9'd1;
    endcase
    if (op == 7'b0000100) begin
      chk("stp_halted", 32'(halted), 32'd1);
      chk("stp_valid", 32'(ins_valid), 32'd0);
      chk("stp_imem_en", 32'(imem_en), 32'd0);
      chk("stp_pc", 32'(pc), 32'(mpc));
    end else begin
      chk("next_imem_en", 32'(imem_en), 32'd1);
      chk("next_imem_addr", 32'(imem_addr), 32'(mpc));
      chk("next_pc", 32'(pc), 32'(mpc));
      chk("next_valid", 32'(ins_valid), 32'd0);
    end
    chk_retcnt();
  endtask

  initial begin
    logic [6:0] rop;
    int         r;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0]    = 16'h0A00;  // ADD 0
    mem[1]    = 16'h0E05;  // LDA 5
    mem[2]    = 16'h1023;  // JMP 0x23
    mem[9'h23] = 16'h1007; // JMP 7
    mem[7]    = 16'h1240;  // BAN 0x40
    mem[9'h40] = 16'h1007; // JMP 7
    mem[8]    = 16'h11FF;  // JMP 511
    mem[511]  = 16'h0A00;  // ADD 0

    do_reset();
    issue(0, 1'b0);        // ADD @0, valid in cycle 3
    issue(5, 1'b0);        // LDA @1 under backpressure
    issue(0, 1'b0);        // JMP 0x23
    issue(0, 1'b1);        // JMP 7
    issue(0, 1'b1);        // BAN taken -> 0x40
    issue(0, 1'b1);        // JMP 7
    issue(0, 1'b0);        // BAN not taken -> 8
    issue(0, 1'b0);        // JMP 511
    mem[0] = 16'h0800;     // STP
    issue(0, 1'b0);        // ADD @511 wraps to 0
    issue(2, 1'b0);        // STP @0
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_valid", 32'(ins_valid), 32'd0);
      chk("halt_imem_en", 32'(imem_en), 32'd0);
      chk("halt_halted", 32'(halted), 32'd1);
    end

    // Reset during S_WAIT must discard the pending word.
    mem[0] = 16'h0A00;
    do_reset();
    @(negedge clk);
    chk("wait_imem_en", 32'(imem_en), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(ins_valid), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_ins", 32'(ins), 32'd0);
    chk("midrst_ins_addr", 32'(ins_addr), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_imem_en", 32'(imem_en), 32'd1);
    chk("midrst_imem_addr", 32'(imem_addr), 32'd0);
    mpc  = '0;
    mret = '0;
    issue(0, 1'b0);
    issue(1, 1'b0);

    // Random program without STP, random backpressure and acc_neg.
    for (int i = 0; i < 512; i++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)      rop = 7'b0001000;
      else if (r == 1) rop = 7'b0001001;
      else             rop = 7'($urandom);
      if (rop == 7'b0000100) rop = 7'b0000101;
      mem[i] = {rop, 9'($urandom)};
    end
    do_reset();
    for (int i = 0; i < 150; i++) begin
      issue(int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
- Upstream neighbour of the control unit in the exp5 accumulator CPU.
- Holds the program counter and fetches instruction words from a synchronous-read instruction memory.
- Latches each word into an instruction register and presents the 7-bit opcode plus address field to the control unit over a valid/ready handshake.
- Resolves JMP/BAN redirection itself and halts fetching on STP.

Parameters:
- ADDR_W, 9: width of PC and instruction address field.
- OP_W, 7: opcode width; matches control-unit `ins`.
- INS_W, OP_W+ADDR_W (16): instruction word width; word = {opcode, addr}.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- imem_en  out  1  instruction memory read enable.
- imem_addr  out  ADDR_W  instruction memory address.
- imem_rdata  in  INS_W  read data; valid one cycle after imem_en.
- ins  out  OP_W  opcode to control unit; equals ir[INS_W-1:ADDR_W].
- ins_addr  out  ADDR_W  operand/address field; equals ir[ADDR_W-1:0].
- ins_valid  out  1  ins/ins_addr valid.
- ins_ready  in  1  control unit accepts the instruction.
- acc_neg  in  1  accumulator sign bit, used by BAN.
- pc  out  ADDR_W  address of the instruction currently held in ir.
- halted  out  1  high once STP has been accepted.
- ret_cnt  out  32  retired-instruction count (present only with FETCH_RETCNT_EN).

Behaviour:
- Reset: synchronous, on any clk edge with rst=1, from any state, including mid-fetch.
  - pc=RESET_PC, ir=0, ins_valid=0, halted=0, imem_en=0.
  - FSM goes to S_FETCH; any in-flight memory data is discarded.
- FSM states: S_FETCH, S_WAIT, S_ISSUE, S_HALT.
- S_FETCH: imem_en=1, imem_addr=pc; next state is S_WAIT.
- S_WAIT: imem_en=0; ir<=imem_rdata at the end of the cycle; next state is S_ISSUE.
- S_ISSUE:
  - ins_valid=1; ins and ins_addr are driven from ir and held stable until the handshake.
  - ins_valid is never withdrawn without a handshake.
  - Handshake = ins_valid && ins_ready, sampled at the rising edge.
  - While ins_ready=0: stay in S_ISSUE, all outputs frozen.
- PC update, on the handshake, by opcode:
  - JMP (7'b0001000): pc<=ins_addr.
  - BAN (7'b0001001): if acc_neg=1, pc<=ins_addr; otherwise pc<=pc+1. acc_neg is sampled in the handshake cycle only.
  - STP (7'b0000100): pc unchanged; halted<=1; next state S_HALT.
  - All other opcodes, including undefined ones: pc<=pc+1 modulo 2^ADDR_W.
  - After every non-STP opcode, next state is S_FETCH.
- S_HALT: ins_valid=0, imem_en=0; only rst leaves this state.
- Throughput and latency:
  - One instruction per 3 cycles with ins_ready held at 1.
  - First ins_valid appears in the 3rd cycle after rst deasserts.
- Wrap-around: pc = 2^ADDR_W-1 followed by an increment gives 0, with no flag.
- JMP/BAN to the current pc is legal (self-loop) and refetches the same word.
- Simultaneous rst and handshake: rst wins; no PC update, no retire count.
- imem_addr: equals pc in every state; only imem_en qualifies the read.

Optional Feature:
- Macro: FETCH_RETCNT_EN.
- When defined:
  - Adds the 32-bit ret_cnt output.
  - ret_cnt increments by 1 on every handshake, including STP, and wraps at 2^32.
  - Cleared by rst.
- When undefined: the ret_cnt port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Sequential run: memory {0:0x0A00 (ADD,0), 1:0x0E05 (LDA,5)}, ins_ready=1.
  - ins=0000101 with pc=0 at cycle 3, then ins=0000111 with pc=1 at cycle 6.
  - imem_en is high exactly in cycles 1 and 4.
- Backpressure: ins_ready=0 for 5 cycles during S_ISSUE.
  - ins_valid stays 1 with ins/ins_addr unchanged and imem_en=0.
  - Accepted on the cycle ready rises; next fetch follows in the next cycle.
- JMP: word 0x1023 (JMP,0x23) at address 2 → after the handshake, imem_addr=0x23 with imem_en=1.
- BAN, two cases on word (BAN,0x40) at pc=7:
  - acc_neg=1 → next fetch address 0x40.
  - acc_neg=0 → next fetch address 8.
- STP and wrap:
  - pc=511 executing ADD → next fetch address 0.
  - STP at address 0 → halted=1; ins_valid and imem_en stay 0 for 20 cycles.
  - rst then restarts fetch from address 0 (ret_cnt=0 when FETCH_RETCNT_EN is defined).
- Reset mid-wait: rst asserted in S_WAIT → next cycle ins_valid=0, pc=0, ir not loaded; fetch restarts at address 0.
